// File: rtl/timer_axi_lite_if.sv
// AXI-Lite bus bundle for the timer peripheral; signal names follow the
// slave's point of view (i_ = into the timer, o_ = out of the timer).
interface timer_axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    i_axi_awvalid;
  logic                    o_axi_awready;
  logic [ADDR_WIDTH-1:0]   i_axi_awaddr;
  logic                    i_axi_wvalid;
  logic                    o_axi_wready;
  logic [DATA_WIDTH-1:0]   i_axi_wdata;
  logic [DATA_WIDTH/8-1:0] i_axi_wstrb;
  logic                    o_axi_bvalid;
  logic                    i_axi_bready;
  logic                    i_axi_arvalid;
  logic                    o_axi_arready;
  logic [ADDR_WIDTH-1:0]   i_axi_araddr;
  logic                    o_axi_rvalid;
  logic                    i_axi_rready;
  logic [DATA_WIDTH-1:0]   o_axi_rdata;

  modport slave (
    input  i_axi_awvalid, i_axi_awaddr, i_axi_wvalid, i_axi_wdata, i_axi_wstrb,
    input  i_axi_bready, i_axi_arvalid, i_axi_araddr, i_axi_rready,
    output o_axi_awready, o_axi_wready, o_axi_bvalid, o_axi_arready,
    output o_axi_rvalid, o_axi_rdata
  );

  modport master (
    output i_axi_awvalid, i_axi_awaddr, i_axi_wvalid, i_axi_wdata, i_axi_wstrb,
    output i_axi_bready, i_axi_arvalid, i_axi_araddr, i_axi_rready,
    input  o_axi_awready, o_axi_wready, o_axi_bvalid, o_axi_arready,
    input  o_axi_rvalid, o_axi_rdata
  );
endinterface

// File: rtl/timer_axi_lite.sv
// Programmable 32-bit timer with AXI-Lite register access.
// Prescaled tick advances COUNT; reaching LOAD sets sticky MATCH and,
// with IRQ_EN, a registered level interrupt.
module timer_axi_lite #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int PRESC_WIDTH = 16
) (
  input  logic              clk,
  input  logic              resetn,
  timer_axi_lite_if.slave   s_axi,
  output logic              irq
);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t r_wstate, w_wstate_nxt;
  r_state_t r_rstate, w_rstate_nxt;

  logic                   w_wr_en;
  logic                   w_rd_en;
  logic [2:0]             w_waddr;
  logic [2:0]             w_raddr;

  logic                   r_en;
  logic                   r_auto;
  logic                   r_irq_en;
  logic [PRESC_WIDTH-1:0] r_presc;
  logic [PRESC_WIDTH-1:0] r_presc_cnt;
  logic [31:0]            r_load;
  logic [31:0]            r_count;
  logic                   r_match;
  logic                   r_irq;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic [31:0]            w_rdata_mux;

  logic                   w_wr_ctrl, w_wr_presc, w_wr_load, w_wr_count, w_wr_status;
  logic [31:0]            w_ctrl_new, w_presc_new, w_load_new, w_count_new;
  logic                   w_tick;
  logic                   w_hit;
  logic                   w_sw_clr;
  logic                   w_unused;

  // Byte-lane merge of write data into an existing register value.
  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
    f_merge = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) f_merge[b*8 +: 8] = new_v[b*8 +: 8];
    end
  endfunction

  assign w_waddr  = s_axi.i_axi_awaddr[4:2];
  assign w_raddr  = s_axi.i_axi_araddr[4:2];
  assign w_unused = ^{s_axi.i_axi_awaddr[ADDR_WIDTH-1:5], s_axi.i_axi_awaddr[1:0],
                      s_axi.i_axi_araddr[ADDR_WIDTH-1:5], s_axi.i_axi_araddr[1:0]};

  // ---------------- write channel ----------------

  // Write FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_wstate <= W_IDLE;
    else         r_wstate <= w_wstate_nxt;
  end

  // Write FSM next state: accept only when address and data arrive together.
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (s_axi.i_axi_awvalid && s_axi.i_axi_wvalid) w_wstate_nxt = W_RESP;
      W_RESP:  if (s_axi.i_axi_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write FSM outputs.
  always_comb begin
    w_wr_en             = (r_wstate == W_IDLE) && s_axi.i_axi_awvalid && s_axi.i_axi_wvalid;
    s_axi.o_axi_awready = w_wr_en;
    s_axi.o_axi_wready  = w_wr_en;
    s_axi.o_axi_bvalid  = (r_wstate == W_RESP);
  end

  // ---------------- read channel ----------------

  // Read FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rstate <= R_IDLE;
    else         r_rstate <= w_rstate_nxt;
  end

  // Read FSM next state.
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (s_axi.i_axi_arvalid) w_rstate_nxt = R_DATA;
      R_DATA:  if (s_axi.i_axi_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read FSM outputs.
  always_comb begin
    w_rd_en             = (r_rstate == R_IDLE) && s_axi.i_axi_arvalid;
    s_axi.o_axi_arready = w_rd_en;
    s_axi.o_axi_rvalid  = (r_rstate == R_DATA);
  end

  // Register read multiplexer.
  always_comb begin
    w_rdata_mux = '0;
    case (w_raddr)
      3'd0:    w_rdata_mux = {29'd0, r_irq_en, r_auto, r_en};
      3'd1:    w_rdata_mux = 32'(r_presc);
      3'd2:    w_rdata_mux = r_load;
      3'd3:    w_rdata_mux = r_count;
      3'd4:    w_rdata_mux = {31'd0, r_match};
      default: w_rdata_mux = '0;
    endcase
  end

  // Read data captured at address acceptance and held until rready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      r_rdata <= '0;
    else if (w_rd_en) r_rdata <= DATA_WIDTH'(w_rdata_mux);
  end

  assign s_axi.o_axi_rdata = r_rdata;

  // ---------------- registers and counting ----------------

  assign w_wr_ctrl   = w_wr_en && (w_waddr == 3'd0);
  assign w_wr_presc  = w_wr_en && (w_waddr == 3'd1);
  assign w_wr_load   = w_wr_en && (w_waddr == 3'd2);
  assign w_wr_count  = w_wr_en && (w_waddr == 3'd3);
  assign w_wr_status = w_wr_en && (w_waddr == 3'd4);

  assign w_ctrl_new  = f_merge({29'd0, r_irq_en, r_auto, r_en}, s_axi.i_axi_wdata, s_axi.i_axi_wstrb);
  assign w_presc_new = f_merge(32'(r_presc), s_axi.i_axi_wdata, s_axi.i_axi_wstrb);
  assign w_load_new  = f_merge(r_load, s_axi.i_axi_wdata, s_axi.i_axi_wstrb);
  assign w_count_new = f_merge(r_count, s_axi.i_axi_wdata, s_axi.i_axi_wstrb);

  assign w_tick   = r_en && (r_presc_cnt == r_presc);
  assign w_hit    = w_tick && (r_count == r_load);
  assign w_sw_clr = w_wr_status && s_axi.i_axi_wstrb[0] && s_axi.i_axi_wdata[0];

  // Control/config registers; a CTRL write overrides the one-shot EN clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_en     <= 1'b0;
      r_auto   <= 1'b0;
      r_irq_en <= 1'b0;
      r_presc  <= '0;
      r_load   <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= w_ctrl_new[0];
        r_auto   <= w_ctrl_new[1];
        r_irq_en <= w_ctrl_new[2];
      end else if (w_hit && !r_auto) begin
        r_en <= 1'b0;
      end
      if (w_wr_presc) r_presc <= w_presc_new[PRESC_WIDTH-1:0];
      if (w_wr_load)  r_load  <= w_load_new;
    end
  end

  // Prescaler and main counter; software writes take priority over the tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_presc_cnt <= '0;
      r_count     <= '0;
    end else begin
      if (!r_en || w_wr_presc || w_wr_count || w_tick) r_presc_cnt <= '0;
      else                                              r_presc_cnt <= r_presc_cnt + 1'b1;
      if (w_wr_count) begin
        r_count <= w_count_new;
      end else if (w_tick) begin
        if (!w_hit)      r_count <= r_count + 32'd1;
        else if (r_auto) r_count <= '0;
      end
    end
  end

  // Sticky match flag (hardware set beats W1C) and registered interrupt.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_match <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_hit)         r_match <= 1'b1;
      else if (w_sw_clr) r_match <= 1'b0;
      r_irq <= r_match && r_irq_en;
    end
  end

  assign irq = r_irq;

endmodule
